// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of the register file's decode/writeback signals.
//
// Handshake: there is no valid/ready pairing on any port. wa_en, wb_en and
// alloc_en are single-cycle qualifiers sampled on every posedge of clk; the
// read addresses are sampled on every posedge without a qualifier. ready is
// status only and never stalls anything: upstream must hold issue until it
// reads 1.
//
// Modports:
//   master - decode/writeback side: drives writes, allocations, read addresses;
//            observes ready, read data, busy flags and the FSM state.
//   slave  - register file side.
// Signals:
//   ready                      1     clear sweep finished
//   wa_en/wb_en                1     write enables, ports A and B
//   wa_addr/wb_addr            AW    write addresses
//   wa_data/wb_data            XLEN  write data
//   alloc_en/alloc_addr        1/AW  mark a destination as pending
//   rs1_addr/rs2_addr          AW    read addresses
//   rs1_data/rs2_data          XLEN  registered read data
//   rs1_busy/rs2_busy          1     registered pending-write flags
//   state_dbg                  1     FSM state (0 = CLEAR, 1 = RUN)
interface regfile_mp_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic            ready;
  logic            wa_en;
  logic            wb_en;
  logic [AW-1:0]   wa_addr;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wa_data;
  logic [XLEN-1:0] wb_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            state_dbg;

  modport master (
    output wa_en, wb_en, wa_addr, wb_addr, wa_data, wb_data,
           alloc_en, alloc_addr, rs1_addr, rs2_addr,
    input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, state_dbg
  );

  modport slave (
    input  wa_en, wb_en, wa_addr, wb_addr, wa_data, wb_data,
           alloc_en, alloc_addr, rs1_addr, rs2_addr,
    output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, state_dbg
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: two-write / two-read register file with a pending-write
// scoreboard and a post-reset clear sweep.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous, active-high reset; restarts the clear sweep
//   bus  - regfile_mp_if.slave (writes, allocation, reads, ready, state_dbg)
// Parameters: XLEN (data width), NREGS (register count, power of 2, >= 4).
// Optional feature macro: REGFILE_BYPASS_EN - when defined, each read port
// forwards same-cycle write data (port B over port A, never for x0).
module regfile_mp #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            rs1_busy_q, rs1_busy_d;
  logic            rs2_busy_q, rs2_busy_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    regs_d     = regs_q;
    rs1_data_d = '0;
    rs2_data_d = '0;
    rs1_busy_d = 1'b0;
    rs2_busy_d = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        // One register per edge; bus traffic is ignored and reads stay 0.
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end

      ST_RUN: begin
        // Port B is applied last so it wins a same-address conflict.
        if (bus.wa_en && (bus.wa_addr != '0)) regs_d[bus.wa_addr] = bus.wa_data;
        if (bus.wb_en && (bus.wb_addr != '0)) regs_d[bus.wb_addr] = bus.wb_data;

        // Allocation is applied after the write clears so it wins.
        if (bus.wa_en)    busy_d[bus.wa_addr]    = 1'b0;
        if (bus.wb_en)    busy_d[bus.wb_addr]    = 1'b0;
        if (bus.alloc_en) busy_d[bus.alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;

        // Read data comes from the pre-edge array contents.
        rs1_data_d = (bus.rs1_addr == '0) ? '0 : regs_q[bus.rs1_addr];
        rs2_data_d = (bus.rs2_addr == '0) ? '0 : regs_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (bus.rs1_addr != '0) begin
          if (bus.wa_en && (bus.wa_addr == bus.rs1_addr)) rs1_data_d = bus.wa_data;
          if (bus.wb_en && (bus.wb_addr == bus.rs1_addr)) rs1_data_d = bus.wb_data;
        end
        if (bus.rs2_addr != '0) begin
          if (bus.wa_en && (bus.wa_addr == bus.rs2_addr)) rs2_data_d = bus.wa_data;
          if (bus.wb_en && (bus.wb_addr == bus.rs2_addr)) rs2_data_d = bus.wb_data;
        end
`endif
        // Busy reflects the scoreboard after this edge's update.
        rs1_busy_d = busy_d[bus.rs1_addr];
        rs2_busy_d = busy_d[bus.rs2_addr];
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  // Array contents are not reset; the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign bus.ready     = ready_q;
  assign bus.rs1_data  = rs1_data_q;
  assign bus.rs2_data  = rs2_data_q;
  assign bus.rs1_busy  = rs1_busy_q;
  assign bus.rs2_busy  = rs2_busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a
// behavioural model (plain arrays and an edge counter).
module tb_regfile_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];
  int              m_edges;       // edges with rst low since last reset
  bit              m_valid = 0;
  logic            exp_ready;
  logic [XLEN-1:0] exp_rs1_data, exp_rs2_data;
  logic            exp_rs1_busy, exp_rs2_busy;

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.wa_en && bus.wa_addr == a) v = bus.wa_data;
    if (bus.wb_en && bus.wb_addr == a) v = bus.wb_data;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_edges = 0;
      exp_ready = 0;
      exp_rs1_data = '0; exp_rs2_data = '0;
      exp_rs1_busy = 0;  exp_rs2_busy = 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    end else if (m_valid && m_edges < NREGS) begin
      m_edges++;
      exp_rs1_data = '0; exp_rs2_data = '0;
      exp_rs1_busy = 0;  exp_rs2_busy = 0;
      if (m_edges == NREGS) begin
        exp_ready = 1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      end
    end else if (m_valid) begin
      exp_rs1_data = m_read(bus.rs1_addr);
      exp_rs2_data = m_read(bus.rs2_addr);
      if (bus.wa_en && bus.wa_addr != 0) m_regs[bus.wa_addr] = bus.wa_data;
      if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.wa_en) m_busy[bus.wa_addr] = 0;
      if (bus.wb_en) m_busy[bus.wb_addr] = 0;
      if (bus.alloc_en) m_busy[bus.alloc_addr] = 1;
      m_busy[0] = 0;
      exp_rs1_busy = m_busy[bus.rs1_addr];
      exp_rs2_busy = m_busy[bus.rs2_addr];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready",    XLEN'(bus.ready),    XLEN'(exp_ready));
      check("rs1_data", bus.rs1_data,        exp_rs1_data);
      check("rs2_data", bus.rs2_data,        exp_rs2_data);
      check("rs1_busy", XLEN'(bus.rs1_busy), XLEN'(exp_rs1_busy));
      check("rs2_busy", XLEN'(bus.rs2_busy), XLEN'(exp_rs2_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wa_en = 0; bus.wb_en = 0; bus.alloc_en = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  task automatic drive_random();
    bus.wa_en      = ($urandom_range(0, 2) != 0);
    bus.wb_en      = ($urandom_range(0, 2) != 0);
    bus.wa_addr    = rnd_addr();
    bus.wb_addr    = rnd_addr();
    bus.wa_data    = {$urandom, $urandom};
    bus.wb_data    = {$urandom, $urandom};
    bus.alloc_en   = ($urandom_range(0, 2) == 0);
    bus.alloc_addr = rnd_addr();
    bus.rs1_addr   = rnd_addr();
    bus.rs2_addr   = rnd_addr();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1;
    idle();
    bus.wa_addr = '0; bus.wb_addr = '0; bus.wa_data = '0; bus.wb_data = '0;
    bus.alloc_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    repeat (3) step();
    check("reset_ready", XLEN'(bus.ready), '0);
    check("reset_busy",  XLEN'(bus.rs1_busy), '0);

    // Sweep: ready 0 for 31 edges, 1 from the 32nd.
    rst = 0;
    bus.rs1_addr = 5;
    for (int i = 1; i <= NREGS + 2; i++) begin
      step();
      check("sweep_ready", XLEN'(bus.ready), XLEN'(i >= NREGS));
      if (i == 10) check("sweep_read_x5", bus.rs1_data, '0);
    end

    // Basic write/read.
    bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 64'hDEADBEEF;
    step(); idle(); bus.rs1_addr = 3;
    step(); check("x3_read", bus.rs1_data, 64'hDEADBEEF);

    bus.wa_en = 1; bus.wa_addr = 0; bus.wa_data = 64'h55;
    step(); idle(); bus.rs1_addr = 0;
    step(); check("x0_read", bus.rs1_data, '0);

    // Dual write conflicts.
    bus.wa_en = 1; bus.wa_addr = 7; bus.wa_data = 64'h11;
    bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 64'h22;
    step(); idle(); bus.rs1_addr = 7;
    step(); check("x7_b_wins", bus.rs1_data, 64'h22);

    bus.wa_en = 1; bus.wa_addr = 8; bus.wa_data = 64'h33;
    bus.wb_en = 1; bus.wb_addr = 9; bus.wb_data = 64'h44;
    step(); idle(); bus.rs1_addr = 8; bus.rs2_addr = 9;
    step();
    check("x8_read", bus.rs1_data, 64'h33);
    check("x9_read", bus.rs2_data, 64'h44);

    // Scoreboard.
    bus.alloc_en = 1; bus.alloc_addr = 10;
    step(); idle(); bus.rs1_addr = 10;
    step(); check("x10_busy", XLEN'(bus.rs1_busy), 1);
    bus.wb_en = 1; bus.wb_addr = 10; bus.wb_data = 64'hA0;
    step(); idle();
    check("x10_cleared", XLEN'(bus.rs1_busy), 0);
    bus.alloc_en = 1; bus.alloc_addr = 10;
    bus.wa_en = 1; bus.wa_addr = 10; bus.wa_data = 64'hA1;
    step(); idle();
    check("x10_alloc_wins", XLEN'(bus.rs1_busy), 1);
    step(); check("x10_busy_hold", XLEN'(bus.rs1_busy), 1);

    // Same-cycle write and read of x4.
    bus.wa_en = 1; bus.wa_addr = 4; bus.wa_data = 64'h12;
    step();
    bus.wa_data = 64'h99; bus.rs2_addr = 4;
    step(); idle();
`ifdef REGFILE_BYPASS_EN
    check("x4_bypass", bus.rs2_data, 64'h99);
`else
    check("x4_no_bypass", bus.rs2_data, 64'h12);
`endif
    step(); check("x4_after", bus.rs2_data, 64'h99);

    // Mid-run reset with random traffic during the sweep.
    bus.wa_en = 1; bus.wa_addr = 2; bus.wa_data = 64'h77;
    step(); idle();
    rst = 1;
    step();
    check("midrst_ready", XLEN'(bus.ready), 0);
    rst = 0;
    for (int i = 1; i <= NREGS; i++) begin
      drive_random();
      step();
      check("midrst_sweep_ready", XLEN'(bus.ready), XLEN'(i == NREGS));
    end
    idle(); bus.rs1_addr = 2; bus.rs2_addr = 10;
    step();
    check("x2_after_rst", bus.rs1_data, '0);
    check("x2_busy_after_rst", XLEN'(bus.rs1_busy), 0);
    check("x10_busy_after_rst", XLEN'(bus.rs2_busy), 0);

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
